// File: rtl/uart_cmd_parser_pkg.sv
// rtl/uart_cmd_parser_pkg.sv - shared frame codes, state encoding and defaults for uart_cmd_parser
package uart_cmd_parser_pkg;

   localparam logic [7:0] SOF_BYTE      = 8'hA5;
   localparam logic [7:0] CMD_SET_WIDTH = 8'h01;
   localparam logic [7:0] CMD_SET_LED   = 8'h02;
   localparam logic [7:0] CMD_RESYNC    = 8'h03;
   localparam logic [7:0] ACK_BYTE      = 8'h06;
   localparam logic [7:0] NAK_BYTE      = 8'h15;
   localparam logic [2:0] DEFAULT_WIDTH = 3'd1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHK
   } state_t;

   // traceIF only supports 1, 2 or 4 lanes
   function automatic logic legal_width(input logic [7:0] w);
      return (w == 8'd1) || (w == 8'd2) || (w == 8'd4);
   endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - SOF/CMD/LEN/payload/CHK frame parser driving trace width, LEDs and resync
module uart_cmd_parser
   import uart_cmd_parser_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 48000,
   parameter int unsigned MAX_LEN        = 4
) (
   input  logic       clkOut,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       received,
   input  logic       recv_error,
   output logic [2:0] width,
   output logic [3:0] led_mask,
   output logic       sync_reset,
   output logic       ack_valid,
   output logic [7:0] ack_byte,
   input  logic       ack_ready,
   output logic [7:0] err_count
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t           state_q, state_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [7:0]       xor_q, xor_d;
   logic [7:0]       payload_q [MAX_LEN];
   logic [7:0]       payload_d [MAX_LEN];
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [2:0]       width_q, width_d;
   logic [3:0]       led_q, led_d;
   logic             sync_q, sync_d;
   logic             ack_valid_q, ack_valid_d;
   logic [7:0]       ack_byte_q, ack_byte_d;
   logic [7:0]       err_q, err_d;

   logic             ack_new;
   logic [7:0]       ack_code;
   logic             err_inc;

   always_ff @(posedge clkOut) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         xor_q       <= '0;
         timer_q     <= '0;
         width_q     <= DEFAULT_WIDTH;
         led_q       <= '0;
         sync_q      <= 1'b0;
         ack_valid_q <= 1'b0;
         ack_byte_q  <= '0;
         err_q       <= '0;
         for (int i = 0; i < int'(MAX_LEN); i++) payload_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         xor_q       <= xor_d;
         timer_q     <= timer_d;
         width_q     <= width_d;
         led_q       <= led_d;
         sync_q      <= sync_d;
         ack_valid_q <= ack_valid_d;
         ack_byte_q  <= ack_byte_d;
         err_q       <= err_d;
         payload_q   <= payload_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      len_d     = len_q;
      idx_d     = idx_q;
      xor_d     = xor_q;
      payload_d = payload_q;
      timer_d   = timer_q;
      width_d   = width_q;
      led_d     = led_q;
      sync_d    = 1'b0;
      ack_new   = 1'b0;
      ack_code  = ACK_BYTE;
      err_inc   = 1'b0;

      // A framing error outranks a byte strobe arriving in the same cycle
      if (recv_error) begin
         timer_d = '0;
         if (state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
         end
      end else if (received) begin
         timer_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == SOF_BYTE) state_d = ST_CMD;
            end
            ST_CMD: begin
               cmd_d   = rx_byte;
               xor_d   = rx_byte;
               state_d = ST_LEN;
            end
            ST_LEN: begin
               if (rx_byte > 8'(MAX_LEN)) begin
                  state_d  = ST_IDLE;
                  ack_new  = 1'b1;
                  ack_code = NAK_BYTE;
                  err_inc  = 1'b1;
               end else begin
                  len_d   = rx_byte[LEN_W-1:0];
                  xor_d   = xor_q ^ rx_byte;
                  idx_d   = '0;
                  state_d = (rx_byte == 8'd0) ? ST_CHK : ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               for (int i = 0; i < int'(MAX_LEN); i++)
                  if (idx_q == LEN_W'(i)) payload_d[i] = rx_byte;
               xor_d = xor_q ^ rx_byte;
               if (idx_q == len_q - LEN_W'(1)) state_d = ST_CHK;
               else                            idx_d   = idx_q + LEN_W'(1);
            end
            ST_CHK: begin
               state_d  = ST_IDLE;
               ack_new  = 1'b1;
               ack_code = NAK_BYTE;
               if (rx_byte == xor_q) begin
                  case (cmd_q)
                     CMD_SET_WIDTH:
                        if (len_q == LEN_W'(1) && legal_width(payload_q[0])) begin
                           width_d  = payload_q[0][2:0];
                           ack_code = ACK_BYTE;
                        end
                     CMD_SET_LED:
                        if (len_q == LEN_W'(1)) begin
                           led_d    = payload_q[0][3:0];
                           ack_code = ACK_BYTE;
                        end
                     CMD_RESYNC:
                        if (len_q == '0) begin
                           sync_d   = 1'b1;
                           ack_code = ACK_BYTE;
                        end
                     default: ack_code = NAK_BYTE;
                  endcase
               end
               err_inc = (ack_code == NAK_BYTE);
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_IDLE;
            timer_d = '0;
            err_inc = 1'b1;
         end else begin
            timer_d = timer_q + TMR_W'(1);
         end
      end else begin
         timer_d = '0;
      end

      // A fresh response always wins, even over a handshake in the same cycle
      ack_valid_d = ack_new | (ack_valid_q & ~ack_ready);
      ack_byte_d  = ack_new ? ack_code : ack_byte_q;
      err_d       = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   end

   assign width      = width_q;
   assign led_mask   = led_q;
   assign sync_reset = sync_q;
   assign ack_valid  = ack_valid_q;
   assign ack_byte   = ack_byte_q;
   assign err_count  = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;
   import uart_cmd_parser_pkg::*;

   localparam int TMO = 48000;

   logic       clkOut = 1'b0;
   logic       rst;
   logic [7:0] rx_byte;
   logic       received;
   logic       recv_error;
   logic [2:0] width;
   logic [3:0] led_mask;
   logic       sync_reset;
   logic       ack_valid;
   logic [7:0] ack_byte;
   logic       ack_ready;
   logic [7:0] err_count;

   uart_cmd_parser #(.TIMEOUT_CYCLES(TMO), .MAX_LEN(4)) dut (
      .clkOut(clkOut), .rst(rst), .rx_byte(rx_byte), .received(received),
      .recv_error(recv_error), .width(width), .led_mask(led_mask),
      .sync_reset(sync_reset), .ack_valid(ack_valid), .ack_byte(ack_byte),
      .ack_ready(ack_ready), .err_count(err_count)
   );

   always #10 clkOut = ~clkOut;

   typedef struct {
      logic [7:0]      pre;
      logic [7:0]      cmd;
      logic [7:0]      len;
      logic [3:0][7:0] pl;
      int              npl;
      int              chk;
      logic [7:0]      exp_ack;
      logic [2:0]      exp_width;
      logic [3:0]      exp_led;
      logic            exp_sync;
   } vec_t;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_err = 8'd0;
   vec_t       vecs[13];

   function automatic vec_t mk(input logic [7:0] pre, input logic [7:0] cmd, input logic [7:0] len,
                               input logic [31:0] pl, input int npl, input int chk,
                               input logic [7:0] ack, input logic [2:0] w, input logic [3:0] led,
                               input logic sync);
      vec_t v;
      v.pre = pre; v.cmd = cmd; v.len = len; v.pl = pl; v.npl = npl; v.chk = chk;
      v.exp_ack = ack; v.exp_width = w; v.exp_led = led; v.exp_sync = sync;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called and returns at a negedge; the strobe is seen on the posedge in between
   task automatic send(input logic [7:0] b);
      rx_byte  = b;
      received = 1'b1;
      @(negedge clkOut);
      received = 1'b0;
   endtask

   // npl < 0 stops after the LEN byte; chk < 0 sends the correct checksum
   task automatic send_frame(input vec_t v);
      logic [7:0] c;
      if (v.pre != 8'h00) send(v.pre);
      send(SOF_BYTE);
      send(v.cmd);
      exp_q.push_back(v.exp_ack);
      if (v.exp_ack == NAK_BYTE && exp_err != 8'hFF) exp_err++;
      send(v.len);
      if (v.npl >= 0) begin
         c = v.cmd ^ v.len;
         for (int i = 0; i < v.npl; i++) begin
            send(v.pl[i]);
            c = c ^ v.pl[i];
         end
         send((v.chk < 0) ? c : 8'(v.chk));
      end
   endtask

   task automatic take_ack(input string name);
      int waited = 0;
      while (!ack_valid && waited < 20) begin
         @(negedge clkOut);
         waited++;
      end
      if (!ack_valid) begin
         check({name, "_ack_timeout"}, 32'(ack_valid), 32'd1);
      end else if (exp_q.size() == 0) begin
         check({name, "_unexpected_ack"}, 32'(ack_byte), 32'hFFFF);
      end else begin
         check({name, "_ack_byte"}, 32'(ack_byte), 32'(exp_q.pop_front()));
         ack_ready = 1'b1;
         @(negedge clkOut);
         ack_ready = 1'b0;
         check({name, "_ack_clear"}, 32'(ack_valid), 32'd0);
         check({name, "_sync_1cyc"}, 32'(sync_reset), 32'd0);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_width"}, 32'(width), 32'd1);
      check({name, "_led"}, 32'(led_mask), 32'd0);
      check({name, "_sync"}, 32'(sync_reset), 32'd0);
      check({name, "_ackv"}, 32'(ack_valid), 32'd0);
      check({name, "_ackb"}, 32'(ack_byte), 32'd0);
      check({name, "_err"}, 32'(err_count), 32'd0);
   endtask

   initial begin
      vecs[0]  = mk(8'h00, 8'h01, 8'h01, 32'h03,       1, -1,    NAK_BYTE, 3'd1, 4'h0, 1'b0);
      vecs[1]  = mk(8'h00, 8'h01, 8'h01, 32'h02,       1, -1,    ACK_BYTE, 3'd2, 4'h0, 1'b0);
      vecs[2]  = mk(8'h00, 8'h01, 8'h01, 32'h04,       1, -1,    ACK_BYTE, 3'd4, 4'h0, 1'b0);
      vecs[3]  = mk(8'h00, 8'h01, 8'h02, 32'h0201,     2, -1,    NAK_BYTE, 3'd4, 4'h0, 1'b0);
      vecs[4]  = mk(8'h00, 8'h02, 8'h01, 32'h5A,       1, -1,    ACK_BYTE, 3'd4, 4'hA, 1'b0);
      vecs[5]  = mk(8'h00, 8'h02, 8'h00, 32'h0,        0, -1,    NAK_BYTE, 3'd4, 4'hA, 1'b0);
      vecs[6]  = mk(8'h00, 8'h03, 8'h00, 32'h0,        0, 8'hFF, NAK_BYTE, 3'd4, 4'hA, 1'b0);
      vecs[7]  = mk(8'h00, 8'h03, 8'h00, 32'h0,        0, -1,    ACK_BYTE, 3'd4, 4'hA, 1'b1);
      vecs[8]  = mk(8'h00, 8'h03, 8'h01, 32'h0,        1, -1,    NAK_BYTE, 3'd4, 4'hA, 1'b0);
      vecs[9]  = mk(8'h00, 8'h07, 8'h00, 32'h0,        0, -1,    NAK_BYTE, 3'd4, 4'hA, 1'b0);
      vecs[10] = mk(8'h00, 8'h02, 8'h04, 32'h0F332211, 4, -1,    NAK_BYTE, 3'd4, 4'hA, 1'b0);
      vecs[11] = mk(8'h00, 8'h01, 8'h05, 32'h0,       -1, -1,    NAK_BYTE, 3'd4, 4'hA, 1'b0);
      vecs[12] = mk(8'h33, 8'h02, 8'h01, 32'h03,       1, -1,    ACK_BYTE, 3'd4, 4'h3, 1'b0);

      rst = 1'b1; rx_byte = 8'h00; received = 1'b0; recv_error = 1'b0; ack_ready = 1'b0;
      repeat (3) @(negedge clkOut);
      rst = 1'b0;
      check_reset_outputs("reset");

      for (int i = 0; i < 13; i++) begin
         send_frame(vecs[i]);
         check($sformatf("v%0d_width", i), 32'(width), 32'(vecs[i].exp_width));
         check($sformatf("v%0d_led", i), 32'(led_mask), 32'(vecs[i].exp_led));
         check($sformatf("v%0d_sync", i), 32'(sync_reset), 32'(vecs[i].exp_sync));
         check($sformatf("v%0d_err", i), 32'(err_count), 32'(exp_err));
         take_ack($sformatf("v%0d", i));
      end

      // back-to-back frames without handshake: second response overwrites the first
      send_frame(mk(8'h00, 8'h02, 8'h01, 32'h01, 1, -1, ACK_BYTE, 3'd4, 4'h1, 1'b0));
      send_frame(mk(8'h00, 8'h09, 8'h00, 32'h0,  0, -1, NAK_BYTE, 3'd4, 4'h1, 1'b0));
      void'(exp_q.pop_front());
      repeat (3) @(negedge clkOut);
      check("b2b_ackv_held", 32'(ack_valid), 32'd1);
      check("b2b_led", 32'(led_mask), 32'h1);
      take_ack("b2b");

      // new response lands in the same cycle as the handshake of the previous one
      send_frame(mk(8'h00, 8'h02, 8'h01, 32'h06, 1, -1, ACK_BYTE, 3'd4, 4'h6, 1'b0));
      send(SOF_BYTE);
      send(8'h09);
      send(8'h00);
      exp_q.push_back(NAK_BYTE);
      exp_err++;
      rx_byte = 8'h09; received = 1'b1; ack_ready = 1'b1;
      @(negedge clkOut);
      received = 1'b0; ack_ready = 1'b0;
      void'(exp_q.pop_front());
      check("hs_same_cycle_ackv", 32'(ack_valid), 32'd1);
      take_ack("hs_same_cycle");

      // recv_error mid-payload, error+byte collision, and error while idle
      send(SOF_BYTE); send(8'h02); send(8'h02); send(8'h11);
      recv_error = 1'b1; @(negedge clkOut); recv_error = 1'b0;
      exp_err++;
      check("rxerr_payload_err", 32'(err_count), 32'(exp_err));
      send(SOF_BYTE);
      rx_byte = 8'h01; received = 1'b1; recv_error = 1'b1;
      @(negedge clkOut);
      received = 1'b0; recv_error = 1'b0;
      exp_err++;
      check("rxerr_collide_err", 32'(err_count), 32'(exp_err));
      recv_error = 1'b1; @(negedge clkOut); recv_error = 1'b0;
      check("rxerr_idle_err", 32'(err_count), 32'(exp_err));
      check("rxerr_no_ack", 32'(ack_valid), 32'd0);
      send_frame(mk(8'h00, 8'h01, 8'h01, 32'h01, 1, -1, ACK_BYTE, 3'd1, 4'h6, 1'b0));
      check("rxerr_recover_width", 32'(width), 32'd1);
      take_ack("rxerr_recover");

      // inter-byte timeout: no abort after TMO-1 idle cycles, abort on the TMO-th
      send(SOF_BYTE); send(8'h02);
      repeat (TMO - 1) @(negedge clkOut);
      check("tmo_not_yet", 32'(err_count), 32'(exp_err));
      @(negedge clkOut);
      exp_err++;
      check("tmo_err", 32'(err_count), 32'(exp_err));
      check("tmo_no_ack", 32'(ack_valid), 32'd0);
      send_frame(mk(8'h00, 8'h02, 8'h01, 32'h09, 1, -1, ACK_BYTE, 3'd1, 4'h9, 1'b0));
      check("tmo_recover_led", 32'(led_mask), 32'h9);
      take_ack("tmo_recover");

      // rst mid-frame with a response pending
      send_frame(mk(8'h00, 8'h01, 8'h01, 32'h04, 1, -1, ACK_BYTE, 3'd4, 4'h9, 1'b0));
      send(SOF_BYTE); send(8'h01); send(8'h01);
      rst = 1'b1; @(negedge clkOut); rst = 1'b0;
      exp_q.delete();
      exp_err = 8'd0;
      check_reset_outputs("midrst");
      send(8'h02); send(8'h02);
      repeat (3) @(negedge clkOut);
      check("midrst_tail_ignored", 32'(ack_valid), 32'd0);
      send_frame(mk(8'h00, 8'h01, 8'h01, 32'h02, 1, -1, ACK_BYTE, 3'd2, 4'h0, 1'b0));
      check("midrst_recover_width", 32'(width), 32'd2);
      take_ack("midrst_recover");

      // err_count saturation via oversize-LEN NAKs
      ack_ready = 1'b1;
      for (int i = 0; i < 260; i++) begin
         send(SOF_BYTE); send(8'h01); send(8'h05);
         if (exp_err != 8'hFF) exp_err++;
      end
      ack_ready = 1'b0;
      exp_q.delete();
      check("err_saturate", 32'(err_count), 32'(exp_err));
      check("err_saturate_ff", 32'(err_count), 32'hFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
